// File: rtl/tone_pkg.sv
// tone_pkg: note codes, note frequencies and period windows shared by tone generator and decoder
package tone_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  localparam logic [3:0] NOTE_C4 = 4'd0;
  localparam logic [3:0] NOTE_D4 = 4'd1;
  localparam logic [3:0] NOTE_E4 = 4'd2;
  localparam logic [3:0] NOTE_F4 = 4'd3;
  localparam logic [3:0] NOTE_G4 = 4'd4;
  localparam logic [3:0] NOTE_A4 = 4'd5;
  localparam logic [3:0] NOTE_B4 = 4'd6;
  localparam logic [3:0] NOTE_E_DI = 4'd7;
  localparam logic [3:0] NOTE_FS = 4'd8;
  localparam logic [3:0] NOTE_UNKNOWN = 4'hF;
  localparam int NUM_NOTES = 9;
  localparam int TOL_SHIFT = 6;
  localparam int unsigned NOTE_FREQ [NUM_NOTES] = '{261, 293, 329, 349, 392, 440, 493, 82, 93};
  // Full period of a generated tone; at 50 MHz this gives 383142, 341298, 303952,
  // 286534, 255104, 227274, 202840, 1219514, 1075270.
  function automatic int unsigned nominal_period(input int unsigned clk_freq, input int n);
    return 2 * (clk_freq / NOTE_FREQ[n] + 1);
  endfunction
  function automatic int unsigned win_lo(input int unsigned clk_freq, input int n);
    return nominal_period(clk_freq, n) - (nominal_period(clk_freq, n) >> TOL_SHIFT);
  endfunction
  function automatic int unsigned win_hi(input int unsigned clk_freq, input int n);
    return nominal_period(clk_freq, n) + (nominal_period(clk_freq, n) >> TOL_SHIFT);
  endfunction
endpackage

// File: rtl/tone_decoder_if.sv
// tone_decoder_if: tone input and decoded note outputs; slave = decoder, master = source/monitor
interface tone_decoder_if #(parameter int PER_W = 24);
  logic tone_in;
  logic [3:0] note_code;
  logic [PER_W-1:0] period_out;
  logic meas_valid;
  logic note_changed;
  logic silent;
  modport slave (input tone_in, output note_code, period_out, meas_valid, note_changed, silent);
  modport master (output tone_in, input note_code, period_out, meas_valid, note_changed, silent);
endinterface

// File: rtl/tone_period_classifier.sv
// tone_period_classifier: maps a registered averaged period to a registered note code and status flags
// Ports: avg/avg_v = new averaged period, clear = timeout (force unknown + silent);
// note_code, period_out, meas_valid, note_changed, silent = registered results.
module tone_period_classifier
  import tone_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int PER_W = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic [PER_W-1:0] avg,
  input  logic avg_v,
  input  logic clear,
  output logic [3:0] note_code,
  output logic [PER_W-1:0] period_out,
  output logic meas_valid,
  output logic note_changed,
  output logic silent
);
  logic [31:0] a;
  logic [3:0] code;
  // Scanning from the top down leaves the lowest matching code in place.
  always_comb begin
    a = 32'(avg);
    code = NOTE_UNKNOWN;
    for (int n = NUM_NOTES - 1; n >= 0; n--)
      code = (a >= win_lo(CLK_FREQ, n) && a <= win_hi(CLK_FREQ, n)) ? 4'(n) : code;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      note_code <= NOTE_UNKNOWN;
      period_out <= '0;
      meas_valid <= 1'b0;
      note_changed <= 1'b0;
      silent <= 1'b1;
    end else begin
      meas_valid <= avg_v;
      note_changed <= avg_v && (code != note_code);
      if (avg_v) begin
        note_code <= code;
        period_out <= avg;
        silent <= 1'b0;
      end else if (clear) begin
        note_code <= NOTE_UNKNOWN;
        silent <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of a square-wave tone, averages it and classifies the note
// Ports: clk, reset (sync, active high); bus.tone_in async tone input;
// bus.note_code/period_out/meas_valid/note_changed/silent decoded results.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int PER_W = 24,
  parameter int unsigned MIN_PERIOD = 100000,
  parameter int unsigned TIMEOUT_CYC = 1500000,
  parameter int AVG_LOG2 = 2
) (
  input logic clk,
  input logic reset,
  tone_decoder_if.slave bus
);
  localparam int AW = PER_W + AVG_LOG2;
  localparam int N = 1 << AVG_LOG2;
  state_t state;
  logic [2:0] sync_q;
  logic [PER_W-1:0] cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [AVG_LOG2:0] pcnt;
  logic [PER_W-1:0] avg_q;
  logic avg_v;
  logic rise_det;
  logic accept;
  logic timeout;
  logic last;
  assign rise_det = sync_q[1] & ~sync_q[2];
  assign accept = rise_det && (state == IDLE || cnt >= PER_W'(MIN_PERIOD));
  assign timeout = state != IDLE && cnt == PER_W'(TIMEOUT_CYC) && !accept;
  assign sum = acc + AW'(cnt);
  assign last = pcnt == (AVG_LOG2 + 1)'(N - 1);
  // Preset high so a tone already high when reset drops is not taken as a rising edge.
  always_ff @(posedge clk)
    sync_q <= reset ? '1 : {sync_q[1:0], bus.tone_in};
  always_ff @(posedge clk)
    cnt <= reset ? '0 : accept ? PER_W'(1) : (&cnt) ? cnt : cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      pcnt <= '0;
      avg_q <= '0;
      avg_v <= 1'b0;
    end else begin
      avg_v <= 1'b0;
      if (accept) begin
        if (state == IDLE) begin
          state <= ARM;
          acc <= '0;
          pcnt <= '0;
        end else if (last) begin
          avg_q <= PER_W'(sum >> AVG_LOG2);
          avg_v <= 1'b1;
          acc <= '0;
          pcnt <= '0;
          state <= MEASURE;
        end else begin
          acc <= sum;
          pcnt <= pcnt + 1'b1;
        end
      end else if (timeout) begin
        state <= IDLE;
        acc <= '0;
        pcnt <= '0;
      end
    end
  end
  tone_period_classifier #(.CLK_FREQ(CLK_FREQ), .PER_W(PER_W)) u_cls (
    .clk(clk),
    .reset(reset),
    .avg(avg_q),
    .avg_v(avg_v),
    .clear(timeout),
    .note_code(bus.note_code),
    .period_out(bus.period_out),
    .meas_valid(bus.meas_valid),
    .note_changed(bus.note_changed),
    .silent(bus.silent)
  );
endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed checks of the tone decoder on a 50 kHz-scaled clock
module tb_tone_decoder;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int since = 0;
  int mv_cnt = 0;
  int nc_cnt = 0;
  int sil_cnt = 0;
  int snap_mv;
  int snap_nc;
  int snap_sil;
  tone_decoder_if #(.PER_W(24)) bus ();
  tone_decoder #(
    .CLK_FREQ(50000),
    .PER_W(24),
    .MIN_PERIOD(100),
    .TIMEOUT_CYC(1500),
    .AVG_LOG2(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!reset) begin
      mv_cnt <= mv_cnt + int'(bus.meas_valid);
      nc_cnt <= nc_cnt + int'(bus.note_changed);
      sil_cnt <= sil_cnt + int'(bus.silent);
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    since += n;
  endtask
  task automatic gap_rise(input int p);
    if (since < p / 2) adv(p / 2 - since);
    bus.tone_in = 1'b0;
    adv(since < p ? p - since : 2);
    bus.tone_in = 1'b1;
    since = 0;
  endtask
  task automatic check_meas(input string tag, input int p, input int code, input int chg, input int sil_before);
    gap_rise(p);
    adv(3);
    chk({tag, ".mv_early"}, 32'(bus.meas_valid), 0);
    chk({tag, ".silent_before"}, 32'(bus.silent), 32'(sil_before));
    adv(1);
    chk({tag, ".mv"}, 32'(bus.meas_valid), 1);
    chk({tag, ".period"}, 32'(bus.period_out), 32'(p));
    chk({tag, ".code"}, 32'(bus.note_code), 32'(code));
    chk({tag, ".changed"}, 32'(bus.note_changed), 32'(chg));
    chk({tag, ".silent"}, 32'(bus.silent), 0);
    adv(1);
    chk({tag, ".mv_width"}, 32'(bus.meas_valid), 0);
  endtask
  initial begin
    reset = 1'b1;
    bus.tone_in = 1'b0;
    adv(3);
    chk("rst.code", 32'(bus.note_code), 32'hF);
    chk("rst.period", 32'(bus.period_out), 0);
    chk("rst.mv", 32'(bus.meas_valid), 0);
    chk("rst.changed", 32'(bus.note_changed), 0);
    chk("rst.silent", 32'(bus.silent), 1);
    reset = 1'b0;
    since = 0;
    // D4: first edge arms, four more complete the average
    repeat (4) gap_rise(342);
    check_meas("d4", 342, 1, 1, 1);
    adv(2);
    chk("d4.mv_count", 32'(mv_cnt), 1);
    // E4 window edge, just outside it, then F4
    repeat (3) gap_rise(308);
    check_meas("e4_hi", 308, 2, 1, 0);
    repeat (3) gap_rise(309);
    check_meas("e4_out", 309, 15, 1, 0);
    repeat (3) gap_rise(288);
    check_meas("f4", 288, 3, 1, 0);
    // G4, then G4 again with a short glitch edge early in the period
    repeat (3) gap_rise(256);
    check_meas("g4", 256, 4, 1, 0);
    adv(60 - since);
    bus.tone_in = 1'b0;
    adv(5);
    bus.tone_in = 1'b1;
    repeat (3) gap_rise(256);
    check_meas("glitch", 256, 4, 0, 0);
    // Stop toggling: silence lands TIMEOUT_CYC+1 cycles after the last accepted edge
    adv(2);
    snap_mv = mv_cnt;
    adv(1502 - since);
    chk("to.silent_early", 32'(bus.silent), 0);
    chk("to.code_early", 32'(bus.note_code), 4);
    adv(1);
    chk("to.silent", 32'(bus.silent), 1);
    chk("to.code", 32'(bus.note_code), 32'hF);
    chk("to.period_kept", 32'(bus.period_out), 256);
    adv(2);
    chk("to.no_mv", 32'(mv_cnt), 32'(snap_mv));
    // A4 resumes from idle
    repeat (4) gap_rise(228);
    check_meas("a4", 228, 5, 1, 1);
    // B4 interrupted by reset after its third edge
    repeat (3) gap_rise(204);
    adv(3);
    reset = 1'b1;
    adv(1);
    chk("mrst.code", 32'(bus.note_code), 32'hF);
    chk("mrst.period", 32'(bus.period_out), 0);
    chk("mrst.mv", 32'(bus.meas_valid), 0);
    chk("mrst.silent", 32'(bus.silent), 1);
    reset = 1'b0;
    adv(2);
    snap_mv = mv_cnt;
    repeat (4) gap_rise(204);
    adv(4);
    chk("b4.no_early_mv", 32'(mv_cnt), 32'(snap_mv));
    check_meas("b4", 204, 6, 1, 1);
    // E_DI then FS without any silence
    adv(2);
    snap_nc = nc_cnt;
    snap_sil = sil_cnt;
    repeat (3) gap_rise(1220);
    check_meas("e_di", 1220, 7, 1, 0);
    repeat (3) gap_rise(1076);
    check_meas("fs", 1076, 8, 1, 0);
    adv(2);
    chk("low.changed_pulses", 32'(nc_cnt - snap_nc), 2);
    chk("low.silent_cycles", 32'(sil_cnt - snap_sil), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
